// File: rtl/lsu_ctrl.sv
// Load/store controller between execute and dmem: one byte/halfword request at a
// time, byte stores done as read-modify-write on the 16-bit dmem word.
module lsu_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic              req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_i,
  output logic              mem_read_i,
  input  logic [DATA_W-1:0] read_data_o
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wbuf_reg, wbuf_next;
  logic                write_reg, size_reg, unsigned_reg;
  logic                resp_valid_reg, resp_valid_next;
  logic                resp_err_reg, resp_err_next;
  logic [DATA_W-1:0]   resp_rdata_reg, resp_rdata_next;

  logic                accept;
  logic                misaligned;
  logic [7:0]          lane_byte;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;

  assign accept     = req_valid_i && (state_reg == IDLE);
  assign misaligned = req_size_i && req_addr_i[0];

  // Little-endian lane pick; the extension only applies to byte loads.
  assign lane_byte = addr_reg[0] ? read_data_o[15:8] : read_data_o[7:0];
  assign load_data = size_reg ? read_data_o :
                     unsigned_reg ? {8'h00, lane_byte} : {{8{lane_byte[7]}}, lane_byte};

  // Store byte sits in wbuf_reg[7:0] until the merge overwrites the buffer.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = (addr_reg[0] == 1'(gi)) ? wbuf_reg[7:0]
                                                       : read_data_o[gi*8 +: 8];
  end

  always_comb begin
    state_next      = state_reg;
    wbuf_next       = wbuf_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          wbuf_next = req_wdata_i;
          if (misaligned) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
          end else if (req_write_i && req_size_i) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: state_next = CAP;
      CAP: begin
        if (write_reg) begin
          wbuf_next  = merged;
          state_next = WR;
        end else begin
          resp_valid_next = 1'b1;
          resp_rdata_next = load_data;
          state_next      = IDLE;
        end
      end
      WR: begin
        resp_valid_next = 1'b1;
        resp_rdata_next = '0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wbuf_reg       <= '0;
      write_reg      <= 1'b0;
      size_reg       <= 1'b0;
      unsigned_reg   <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wbuf_reg       <= wbuf_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept) begin
        addr_reg     <= req_addr_i;
        write_reg    <= req_write_i;
        size_reg     <= req_size_i;
        unsigned_reg <= req_unsigned_i;
      end
    end
  end

  assign req_ready_o  = (state_reg == IDLE);
  assign mem_read_i   = (state_reg == RD);
  assign mem_write_i  = (state_reg == WR);
  assign address      = {1'b0, addr_reg[ADDR_W-1:1]};
  assign mem_data     = wbuf_reg;
  assign resp_valid_o = resp_valid_reg;
  assign resp_err_o   = resp_err_reg;
  assign resp_rdata_o = resp_rdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table for single requests plus hand-written
// back-to-back and reset-abort sequences against a simple dmem model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic        req_size_i = 1'b0;
  logic        req_unsigned_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [15:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [15:0] resp_rdata_o;
  logic [15:0] address;
  logic [15:0] mem_data;
  logic        mem_write_i;
  logic        mem_read_i;
  logic [15:0] read_data_o = '0;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  int rd_total = 0, wr_total = 0, overlap_cnt = 0;
  logic [15:0] last_waddr = '0, last_wdata = '0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .address(address), .mem_data(mem_data),
    .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .read_data_o(read_data_o)
  );

  // dmem: synchronous write, read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_write_i) mem[address] <= mem_data;
    if (mem_read_i) read_data_o <= mem[address];
  end

  always @(negedge clk) begin
    if (mem_read_i) rd_total++;
    if (mem_write_i) begin
      wr_total++;
      last_waddr = address;
      last_wdata = mem_data;
    end
    if (mem_read_i && mem_write_i) overlap_cnt++;
  end

  typedef struct {
    logic        write;
    logic        size;
    logic        uns;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [15:0] exp_waddr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int rd0, wr0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_write_i = v.write;
    req_size_i = v.size;
    req_unsigned_i = v.uns;
    req_addr_i = v.addr;
    req_wdata_i = v.wdata;
    rd0 = rd_total;
    wr0 = wr_total;
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 12) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, ".err"}, 32'(resp_err_o), 32'(v.exp_err));
    chk({tag, ".rdata"}, 32'(resp_rdata_o), 32'(v.exp_rdata));
    chk({tag, ".reads"}, 32'(rd_total - rd0), 32'(v.exp_rd));
    chk({tag, ".writes"}, 32'(wr_total - wr0), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      chk({tag, ".waddr"}, 32'(last_waddr), 32'(v.exp_waddr));
      chk({tag, ".wdata"}, 32'(last_wdata), 32'(v.exp_wdata));
    end
    @(posedge clk);
    #1 chk({tag, ".pulse_end"}, 32'(resp_valid_o), 32'd0);
    $display("%s: w=%0b sz=%0b u=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
             tag, v.write, v.size, v.uns, v.addr, v.wdata, lat, v.exp_err, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    int w0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    //            wr    sz    u     addr      wdata     rdata     err  lat rd wr waddr     wdata
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 1'b0, 2, 0, 1, 16'h0000, 16'hABCD};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h0012, 16'h0000, 1'b0, 4, 1, 1, 16'h0000, 16'h12CD};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h12CD, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0080, 16'h0000, 1'b0, 4, 1, 1, 16'h0002, 16'h0080};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'hFF80, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0080, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 1'b0, 4, 1, 1, 16'h7FFF, 16'hA500};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFA5, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h12CD, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hBE7F, 16'h0000, 1'b0, 4, 1, 1, 16'h0000, 16'h127F};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h127F, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0007, 16'h1234, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0008, 16'h8001, 16'h0000, 1'b0, 2, 0, 1, 16'h0004, 16'h8001};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 16'h0008, 16'h0000, 16'h8001, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};

    // Reset state, with a request offered while reset is held
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_size_i = 1'b1;
    req_wdata_i = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", 32'(req_ready_o), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid_o), 32'd0);
    chk("reset.resp_err", 32'(resp_err_o), 32'd0);
    chk("reset.resp_rdata", 32'(resp_rdata_o), 32'd0);
    chk("reset.mem_read", 32'(mem_read_i), 32'd0);
    chk("reset.mem_write", 32'(mem_write_i), 32'd0);
    chk("reset.address", 32'(address), 32'd0);
    chk("reset.mem_data", 32'(mem_data), 32'd0);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset.no_write", 32'(wr_total), 32'd0);
    $display("reset: outputs idle, request during reset ignored");

    for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: valid held high across three requests
    @(negedge clk);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_size_i = 1'b1;
    req_unsigned_i = 1'b0;
    req_addr_i = 16'h0010;
    req_wdata_i = 16'h1111;
    @(posedge clk);
    #1;
    req_write_i = 1'b0;
    chk("b2b.r1_busy", 32'(req_ready_o), 32'd0);
    chk("b2b.r1_novalid", 32'(resp_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("b2b.r1_valid", 32'(resp_valid_o), 32'd1);
    chk("b2b.r1_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_addr_i = 16'h0011;
    chk("b2b.r2_busy", 32'(req_ready_o), 32'd0);
    chk("b2b.r1_pulse_end", 32'(resp_valid_o), 32'd0);
    @(posedge clk);
    #1 chk("b2b.r2_early", 32'(resp_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("b2b.r2_valid", 32'(resp_valid_o), 32'd1);
    chk("b2b.r2_rdata", 32'(resp_rdata_o), 32'h1111);
    chk("b2b.r2_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    chk("b2b.r3_valid", 32'(resp_valid_o), 32'd1);
    chk("b2b.r3_err", 32'(resp_err_o), 32'd1);
    chk("b2b.r3_rdata", 32'(resp_rdata_o), 32'd0);
    @(posedge clk);
    #1 chk("b2b.r3_pulse_end", 32'(resp_valid_o), 32'd0);
    $display("b2b: store 0010, load 0010 -> 1111, misaligned load 0011 -> err");

    // Reset during the CAP cycle of a byte store must suppress the write
    v = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555, 16'h0000, 1'b0, 2, 0, 1, 16'h0000, 16'h5555};
    run_vec(v, "rst.prep");
    @(negedge clk);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_size_i = 1'b0;
    req_addr_i = 16'h0000;
    req_wdata_i = 16'h0034;
    w0 = wr_total;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    chk("rst.rd_strobe", 32'(mem_read_i), 32'd1);
    @(posedge clk);
    #1;
    chk("rst.cap_no_read", 32'(mem_read_i), 32'd0);
    chk("rst.cap_no_write", 32'(mem_write_i), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    chk("rst.mem_write", 32'(mem_write_i), 32'd0);
    chk("rst.mem_read", 32'(mem_read_i), 32'd0);
    chk("rst.address", 32'(address), 32'd0);
    chk("rst.mem_data", 32'(mem_data), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid_o), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.no_resp", 32'(resp_valid_o), 32'd0);
    chk("rst.no_write", 32'(wr_total - w0), 32'd0);
    $display("rst: byte store aborted in CAP, no write issued");
    v = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 3, 1, 0, 16'h0000, 16'h0000};
    run_vec(v, "rst.reload");

    chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
